front_dispatch_buffer: RTL and testbench

FRONT_DISPATCH_BUFFER -- requirements
Module: front_dispatch_buffer

---
 rtl/front_dispatch_buffer.sv | 110 +++++++++++
 tb/tb_front_dispatch_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/front_dispatch_buffer.sv
// Group FIFO between rename and backend dispatch. Holds whole dispatch groups.
// Each lane of a group is given an execution unit, round-robin, when the group is written.
module front_dispatch_buffer #(
   parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
   parameter int NUM_EXEC_UNITS                = 4,
   parameter int GROUP_FIFO_DEPTH              = 4,
   parameter int ENTRY_WIDTH                   = 32,
   localparam int N                   = NUM_PARALLEL_INSTR_DISPATCHES,
   localparam int LOG2_NUM_EXEC_UNITS = $clog2(NUM_EXEC_UNITS),
   localparam int PTR_W               = $clog2(GROUP_FIFO_DEPTH),
   localparam int OCC_W               = $clog2(GROUP_FIFO_DEPTH + 1)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    flush_i,
   input  logic [N-1:0][ENTRY_WIDTH-1:0]           instr_i,
   input  logic [N-1:0]                            instr_valid_i,
   output logic                                    instr_ready_o,
   output logic [N-1:0][ENTRY_WIDTH-1:0]           instr_dispatch_o,
   output logic [N-1:0]                            instr_dispatch_valid_o,
   output logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]   dispatched_instr_alloc_euidx_o,
   input  logic                                    instr_dispatch_ready_i,
   output logic [OCC_W-1:0]                        occupancy_o
);

   localparam logic [OCC_W-1:0]               OCC_FULL = OCC_W'(GROUP_FIFO_DEPTH);
   localparam logic [OCC_W-1:0]               OCC_ONE  = OCC_W'(1);
   localparam logic [PTR_W-1:0]               PTR_ONE  = PTR_W'(1);
   localparam logic [LOG2_NUM_EXEC_UNITS-1:0] EU_ONE   = LOG2_NUM_EXEC_UNITS'(1);

   logic [N-1:0][ENTRY_WIDTH-1:0]         mem_instr [GROUP_FIFO_DEPTH];
   logic [N-1:0]                          mem_valid [GROUP_FIFO_DEPTH];
   logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0] mem_euidx [GROUP_FIFO_DEPTH];

   logic [PTR_W-1:0]                      rd_ptr;
   logic [PTR_W-1:0]                      wr_ptr;
   logic [OCC_W-1:0]                      occ;
   logic [LOG2_NUM_EXEC_UNITS-1:0]        rr_ptr;
   logic [LOG2_NUM_EXEC_UNITS-1:0]        rr_next;
   logic [LOG2_NUM_EXEC_UNITS-1:0]        valid_cnt;
   logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0] alloc_euidx;
   logic                                  push;
   logic                                  pop;
   logic                                  empty;

   assign empty         = (occ == '0);
   assign instr_ready_o = (occ != OCC_FULL);
   assign occupancy_o   = occ;
   assign push          = instr_ready_o & (|instr_valid_i) & ~flush_i;
   assign pop           = ~empty & instr_dispatch_ready_i & ~flush_i;

   // Lane k takes rr_ptr plus the number of valid lanes below it; EU count is a power of two so wrap is free.
   always_comb begin
      valid_cnt   = '0;
      alloc_euidx = '0;
      for (int k = 0; k < N; k++) begin
         if (instr_valid_i[k]) begin
            alloc_euidx[k] = rr_ptr + valid_cnt;
            valid_cnt      = valid_cnt + EU_ONE;
         end
      end
      rr_next = rr_ptr + valid_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         rr_ptr <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            rr_ptr <= rr_next;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // Storage needs no reset: nothing is presented unless occupancy says the slot is live.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_instr[wr_ptr] <= instr_i;
         mem_valid[wr_ptr] <= instr_valid_i;
         mem_euidx[wr_ptr] <= alloc_euidx;
      end
   end

   always_comb begin
      instr_dispatch_o               = '0;
      instr_dispatch_valid_o         = '0;
      dispatched_instr_alloc_euidx_o = '0;
      if (!empty) begin
         instr_dispatch_o               = mem_instr[rd_ptr];
         instr_dispatch_valid_o         = mem_valid[rd_ptr];
         dispatched_instr_alloc_euidx_o = mem_euidx[rd_ptr];
      end
   end

endmodule

// File: tb/tb_front_dispatch_buffer.sv
// Scoreboard bench for front_dispatch_buffer: expected groups are queued at push time.
// A separate negedge monitor checks the head group and retires it on each accepted dispatch.
module tb_front_dispatch_buffer;

   localparam int N     = 4;
   localparam int NEU   = 4;
   localparam int DEPTH = 4;
   localparam int EW    = 16;

   typedef struct {
      logic [N-1:0][EW-1:0] d;
      logic [N-1:0]         v;
      logic [N-1:0][1:0]    e;
   } grp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 flush_i;
   logic [N-1:0][EW-1:0] instr_i;
   logic [N-1:0]         instr_valid_i;
   logic                 instr_ready_o;
   logic [N-1:0][EW-1:0] instr_dispatch_o;
   logic [N-1:0]         instr_dispatch_valid_o;
   logic [N-1:0][1:0]    dispatched_instr_alloc_euidx_o;
   logic                 instr_dispatch_ready_i;
   logic [2:0]           occupancy_o;

   grp_t exp_q[$];
   int   rr_m;
   int   tests;
   int   fails;
   bit   mon_en;

   front_dispatch_buffer #(
      .NUM_PARALLEL_INSTR_DISPATCHES(N),
      .NUM_EXEC_UNITS(NEU),
      .GROUP_FIFO_DEPTH(DEPTH),
      .ENTRY_WIDTH(EW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush_i(flush_i),
      .instr_i(instr_i),
      .instr_valid_i(instr_valid_i),
      .instr_ready_o(instr_ready_o),
      .instr_dispatch_o(instr_dispatch_o),
      .instr_dispatch_valid_o(instr_dispatch_valid_o),
      .dispatched_instr_alloc_euidx_o(dispatched_instr_alloc_euidx_o),
      .instr_dispatch_ready_i(instr_dispatch_ready_i),
      .occupancy_o(occupancy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; the reference model advances right after the edge.
   task automatic cycle(input logic rst, input logic fl, input logic [N-1:0] v, input logic rdy);
      logic       push_ok;
      logic [3:0] below;
      grp_t       g;
      reset                  = rst;
      flush_i                = fl;
      instr_valid_i          = v;
      instr_dispatch_ready_i = rdy;
      for (int k = 0; k < N; k++) instr_i[k] = EW'($urandom_range(0, 65535));
      push_ok = !rst && !fl && (v != 0) && (exp_q.size() != DEPTH);
      g.d = instr_i;
      g.v = v;
      for (int k = 0; k < N; k++) begin
         below  = (4'b0001 << k) - 4'b0001;
         g.e[k] = v[k] ? 2'((rr_m + $countones(v & below)) % NEU) : 2'd0;
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         rr_m   = 0;
         mon_en = 1'b1;
      end else if (fl) begin
         exp_q.delete();
      end else if (push_ok) begin
         exp_q.push_back(g);
         rr_m = (rr_m + $countones(v)) % NEU;
      end
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
   endtask

   initial begin : monitor
      int exp_occ;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            exp_occ = exp_q.size();
            check("occupancy", 64'(occupancy_o), 64'(exp_occ));
            check("instr_ready", 64'(instr_ready_o), 64'(exp_occ != DEPTH));
            if (exp_occ != 0) begin
               check("valid_mask", 64'(instr_dispatch_valid_o), 64'(exp_q[0].v));
               check("group_data", 64'(instr_dispatch_o), 64'(exp_q[0].d));
               check("euidx", 64'(dispatched_instr_alloc_euidx_o), 64'(exp_q[0].e));
               if (instr_dispatch_ready_i && !flush_i && !reset) void'(exp_q.pop_front());
            end else begin
               check("empty_valid", 64'(instr_dispatch_valid_o), 64'd0);
               check("empty_data", 64'(instr_dispatch_o), 64'd0);
               check("empty_euidx", 64'(dispatched_instr_alloc_euidx_o), 64'd0);
            end
         end
      end
   end

   initial begin
      logic rst_r;
      logic fl_r;
      logic rdy_r;
      logic [N-1:0] v_r;
      reset = 1'b1; flush_i = 1'b0; instr_valid_i = '0; instr_i = '0; instr_dispatch_ready_i = 1'b0;
      tests = 0; fails = 0; rr_m = 0; mon_en = 1'b0;
      #1;
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);

      // full group after reset lands on EUs 0..3
      cycle(1'b0, 1'b0, 4'b1111, 1'b0);
      cycle(1'b0, 1'b0, 4'b0000, 1'b0);
      drain(2);

      // sparse groups: lanes 0,2 then lanes 0..2
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 1'b0, 4'b0101, 1'b0);
      cycle(1'b0, 1'b0, 4'b0111, 1'b0);
      cycle(1'b0, 1'b0, 4'b0001, 1'b0);
      drain(4);

      // fill to capacity, then a rejected push alongside a pop
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 4'b1111, 1'b0);
      cycle(1'b0, 1'b0, 4'b1011, 1'b1);
      drain(5);

      // steady push+pop at occupancy 2 across pointer wrap
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 1'b0, 4'b1100, 1'b0);
      cycle(1'b0, 1'b0, 4'b0011, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 4'($urandom_range(1, 15)), 1'b1);
      drain(4);

      // flush overrides push and pop; rr pointer survives it
      cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 1'b0, 4'b0111, 1'b0);
      cycle(1'b0, 1'b0, 4'b0001, 1'b0);
      cycle(1'b0, 1'b0, 4'b1000, 1'b0);
      cycle(1'b0, 1'b1, 4'b1111, 1'b1);
      cycle(1'b0, 1'b0, 4'b1111, 1'b0);
      drain(3);

      // all-invalid group is ignored
      cycle(1'b0, 1'b0, 4'b0110, 1'b0);
      cycle(1'b0, 1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 1'b0, 4'b1001, 1'b0);
      drain(4);

      for (int i = 0; i < 3000; i++) begin
         rst_r = ($urandom_range(0, 299) == 0);
         fl_r  = ($urandom_range(0, 24) == 0);
         v_r   = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         rdy_r = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle(rst_r, fl_r, v_r, rdy_r);
      end
      drain(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
